rs_dispatch_receiver: RTL and testbench

//   Reservation station: receiving end of the dispatch->RS handshake. Captures
//   non-memory instructions on dispatch_rs_rdy, tracks operand readiness by ROB
//   tag, snoops the CDB for wakeups, and issues one fully ready entry per cycle
//   to the ALU. Sits between dispatch/register file/ROB and the ALU.

---
 rtl/rs_dispatch_receiver_pkg.sv | 24 ++
 rtl/rs_dispatch_receiver_pick_lowest.sv | 23 ++
 rtl/rs_dispatch_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_rs_dispatch_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_dispatch_receiver_pkg.sv
// Shared widths, default depth and the issue bundle used by the reservation station.
package rs_dispatch_receiver_pkg;

    localparam int INST_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int IMM_W     = 32;
    localparam int DATA_W    = 32;
    localparam int ROB_TAG_W = 4;
    localparam int RS_DEPTH  = 8;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] npc;
        logic [IMM_W-1:0]  imme;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } alu_issue_t;

    // A pending operand is satisfied by a valid broadcast carrying its tag.
    function automatic logic snoop_hit(input logic cdb_valid, input logic busy, input logic tag_eq);
        return cdb_valid && busy && tag_eq;
    endfunction

endpackage

// File: rtl/rs_dispatch_receiver_pick_lowest.sv
// Priority encoder: index of the lowest set request bit, plus a found flag.
module rs_pick_lowest #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk downward so the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_dispatch_receiver.sv
// Reservation station receiving dispatched instructions, snooping the CDB for
// operand wakeup and issuing one ready entry per cycle to the ALU.
module rs_dispatch_receiver
    import rs_dispatch_receiver_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              dispatch_rs_rdy,
    input  logic [INST_W-1:0] to_inst,
    input  logic [ADDR_W-1:0] to_npc,
    input  logic [IMM_W-1:0]  to_imme,
    input  logic              rs1_busy,
    input  logic [TAG_W-1:0]  rs1_tag,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic              rs2_busy,
    input  logic [TAG_W-1:0]  rs2_tag,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic [TAG_W-1:0]  rob_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    output logic              rs_full,
    output logic              alu_valid,
    output logic [INST_W-1:0] alu_inst,
    output logic [ADDR_W-1:0] alu_npc,
    output logic [IMM_W-1:0]  alu_imme,
    output logic [DATA_W-1:0] alu_v1,
    output logic [DATA_W-1:0] alu_v2,
    output logic [TAG_W-1:0]  alu_dest
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             valid_q,   valid_d;
    logic [DEPTH-1:0][INST_W-1:0] inst_q,    inst_d;
    logic [DEPTH-1:0][ADDR_W-1:0] npc_q,     npc_d;
    logic [DEPTH-1:0][IMM_W-1:0]  imme_q,    imme_d;
    logic [DEPTH-1:0]             q1_busy_q, q1_busy_d;
    logic [DEPTH-1:0][TAG_W-1:0]  q1_tag_q,  q1_tag_d;
    logic [DEPTH-1:0][DATA_W-1:0] v1_q,      v1_d;
    logic [DEPTH-1:0]             q2_busy_q, q2_busy_d;
    logic [DEPTH-1:0][TAG_W-1:0]  q2_tag_q,  q2_tag_d;
    logic [DEPTH-1:0][DATA_W-1:0] v2_q,      v2_d;
    logic [DEPTH-1:0][TAG_W-1:0]  dest_q,    dest_d;

    alu_issue_t       alu_q, alu_d;
    logic [TAG_W-1:0] alu_dest_q, alu_dest_d;
    logic             alu_valid_q, alu_valid_d;
    logic             rs_full_q, rs_full_d;

    logic [DEPTH-1:0] free_req, ready_req;
    logic [IDX_W-1:0] free_idx, issue_idx;
    logic             free_found, issue_found;
    logic             rs1_hit, rs2_hit, do_alloc;
    logic [CNT_W-1:0] occ;

    // Eligibility is judged on start-of-cycle state, so an entry allocated or
    // woken this cycle cannot issue before the next one.
    always_comb begin
        free_req  = ~valid_q;
        ready_req = valid_q & ~q1_busy_q & ~q2_busy_q;
    end

    rs_pick_lowest #(.N(DEPTH), .IDX_W(IDX_W)) u_pick_free (
        .req   (free_req),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick_lowest #(.N(DEPTH), .IDX_W(IDX_W)) u_pick_issue (
        .req   (ready_req),
        .idx   (issue_idx),
        .found (issue_found)
    );

    assign rs1_hit  = snoop_hit(cdb_valid, rs1_busy, rs1_tag == cdb_tag);
    assign rs2_hit  = snoop_hit(cdb_valid, rs2_busy, rs2_tag == cdb_tag);
    assign do_alloc = dispatch_rs_rdy && free_found && !clear;

    always_comb begin
        valid_d     = valid_q;
        inst_d      = inst_q;
        npc_d       = npc_q;
        imme_d      = imme_q;
        q1_busy_d   = q1_busy_q;
        q1_tag_d    = q1_tag_q;
        v1_d        = v1_q;
        q2_busy_d   = q2_busy_q;
        q2_tag_d    = q2_tag_q;
        v2_d        = v2_q;
        dest_d      = dest_q;
        alu_d       = alu_q;
        alu_dest_d  = alu_dest_q;
        alu_valid_d = alu_valid_q;
        rs_full_d   = rs_full_q;
        occ         = '0;

        if (rdy_in) begin
            alu_valid_d = 1'b0;
            if (clear) begin
                valid_d   = '0;
                rs_full_d = 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && snoop_hit(cdb_valid, q1_busy_q[i], q1_tag_q[i] == cdb_tag)) begin
                        q1_busy_d[i] = 1'b0;
                        v1_d[i]      = cdb_val;
                    end
                    if (valid_q[i] && snoop_hit(cdb_valid, q2_busy_q[i], q2_tag_q[i] == cdb_tag)) begin
                        q2_busy_d[i] = 1'b0;
                        v2_d[i]      = cdb_val;
                    end
                end

                if (issue_found) begin
                    valid_d[issue_idx] = 1'b0;
                    alu_valid_d        = 1'b1;
                    alu_d.inst         = inst_q[issue_idx];
                    alu_d.npc          = npc_q[issue_idx];
                    alu_d.imme         = imme_q[issue_idx];
                    alu_d.v1           = v1_q[issue_idx];
                    alu_d.v2           = v2_q[issue_idx];
                    alu_dest_d         = dest_q[issue_idx];
                end

                // Free slot comes from start-of-cycle state, so it never
                // aliases the entry issuing on this same edge.
                if (do_alloc) begin
                    valid_d[free_idx]   = 1'b1;
                    inst_d[free_idx]    = to_inst;
                    npc_d[free_idx]     = to_npc;
                    imme_d[free_idx]    = to_imme;
                    q1_busy_d[free_idx] = rs1_busy && !rs1_hit;
                    q1_tag_d[free_idx]  = rs1_tag;
                    v1_d[free_idx]      = rs1_hit ? cdb_val : rs1_val;
                    q2_busy_d[free_idx] = rs2_busy && !rs2_hit;
                    q2_tag_d[free_idx]  = rs2_tag;
                    v2_d[free_idx]      = rs2_hit ? cdb_val : rs2_val;
                    dest_d[free_idx]    = rob_tag;
                end

                for (int i = 0; i < DEPTH; i++) begin
                    occ = occ + CNT_W'(valid_d[i]);
                end
                // One slot of slack absorbs the instruction already in the
                // dispatch register when full is seen.
                rs_full_d = (occ >= CNT_W'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_q     <= '0;
            inst_q      <= '0;
            npc_q       <= '0;
            imme_q      <= '0;
            q1_busy_q   <= '0;
            q1_tag_q    <= '0;
            v1_q        <= '0;
            q2_busy_q   <= '0;
            q2_tag_q    <= '0;
            v2_q        <= '0;
            dest_q      <= '0;
            alu_q       <= '0;
            alu_dest_q  <= '0;
            alu_valid_q <= 1'b0;
            rs_full_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            npc_q       <= npc_d;
            imme_q      <= imme_d;
            q1_busy_q   <= q1_busy_d;
            q1_tag_q    <= q1_tag_d;
            v1_q        <= v1_d;
            q2_busy_q   <= q2_busy_d;
            q2_tag_q    <= q2_tag_d;
            v2_q        <= v2_d;
            dest_q      <= dest_d;
            alu_q       <= alu_d;
            alu_dest_q  <= alu_dest_d;
            alu_valid_q <= alu_valid_d;
            rs_full_q   <= rs_full_d;
        end
    end

    assign rs_full   = rs_full_q;
    assign alu_valid = alu_valid_q;
    assign alu_inst  = alu_q.inst;
    assign alu_npc   = alu_q.npc;
    assign alu_imme  = alu_q.imme;
    assign alu_v1    = alu_q.v1;
    assign alu_v2    = alu_q.v2;
    assign alu_dest  = alu_dest_q;

    // Dispatch must honour rs_full; an instruction arriving with no free slot is lost.
    a_dispatch_into_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(rdy_in && !clear && dispatch_rs_rdy && !free_found));

endmodule

// File: tb/tb_rs_dispatch_receiver.sv
// Directed bench: expected issues are queued at dispatch time and matched
// (content and issue cycle) whenever the ALU port pulses.
module tb_rs_dispatch_receiver;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clear, dispatch_rs_rdy;
    logic [31:0] to_inst, to_npc, to_imme;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag, rob_tag, cdb_tag;
    logic [31:0] rs1_val, rs2_val, cdb_val;
    logic        cdb_valid;
    logic        rs_full, alu_valid;
    logic [31:0] alu_inst, alu_npc, alu_imme, alu_v1, alu_v2;
    logic [3:0]  alu_dest;

    typedef struct {
        logic [31:0] inst, npc, imme, v1, v2;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   freeze = 1'b0;
    int   e0, w;

    rs_dispatch_receiver dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
        .dispatch_rs_rdy(dispatch_rs_rdy), .to_inst(to_inst), .to_npc(to_npc), .to_imme(to_imme),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val),
        .rob_tag(rob_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_inst(alu_inst), .alu_npc(alu_npc),
        .alu_imme(alu_imme), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_dest(alu_dest)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input logic [31:0] inst, npc, imme, v1, v2,
                                input logic [3:0] dest, input int at);
        exp_t e;
        e.inst = inst; e.npc = npc; e.imme = imme; e.v1 = v1; e.v2 = v2;
        e.dest = dest; e.cyc = at;
        sb.push_back(e);
    endtask

    // Advance one edge, then settle and score the ALU port.
    task automatic tick();
        exp_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        if (!freeze) begin
            if (alu_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_issue", 32'(alu_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("issue_cycle", cyc, e.cyc);
                    chk("alu_inst", alu_inst, e.inst);
                    chk("alu_npc", alu_npc, e.npc);
                    chk("alu_imme", alu_imme, e.imme);
                    chk("alu_v1", alu_v1, e.v1);
                    chk("alu_v2", alu_v2, e.v2);
                    chk("alu_dest", 32'(alu_dest), 32'(e.dest));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_issue", 32'(alu_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    endtask

    // One-cycle dispatch pulse; returns the edge that captured it.
    task automatic dispatch(input logic [31:0] inst, npc, imme,
                            input logic b1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic b2, input logic [3:0] t2, input logic [31:0] v2,
                            input logic [3:0] rob, output int edge_no);
        to_inst = inst; to_npc = npc; to_imme = imme;
        rs1_busy = b1; rs1_tag = t1; rs1_val = v1;
        rs2_busy = b2; rs2_tag = t2; rs2_val = v2;
        rob_tag = rob;
        dispatch_rs_rdy = 1'b1;
        tick();
        dispatch_rs_rdy = 1'b0;
        edge_no = cyc;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; dispatch_rs_rdy = 1'b0;
        to_inst = '0; to_npc = '0; to_imme = '0;
        rs1_busy = 1'b0; rs1_tag = '0; rs1_val = '0;
        rs2_busy = 1'b0; rs2_tag = '0; rs2_val = '0;
        rob_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
        tick(); tick();
        chk("rst_alu_valid", 32'(alu_valid), 32'd0);
        chk("rst_rs_full", 32'(rs_full), 32'd0);
        chk("rst_alu_inst", alu_inst, 32'd0);
        chk("rst_alu_v1", alu_v1, 32'd0);
        chk("rst_alu_dest", 32'(alu_dest), 32'd0);
        rst_n_in = 1'b1;
        tick();

        // T1: both operands ready, issue two edges after dispatch is presented
        dispatch(32'h00B50533, 32'h100, 32'h0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3, e0);
        expect_issue(32'h00B50533, 32'h100, 32'h0, 32'd5, 32'd7, 4'd3, e0 + 1);
        tick(); tick();

        // T2: rs1 waits on tag 2 until a later broadcast
        dispatch(32'h00110133, 32'h104, 32'h0, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd0, 32'd1, 4'd4, e0);
        tick(); tick();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h10;
        tick();
        cdb_valid = 1'b0;
        expect_issue(32'h00110133, 32'h104, 32'h0, 32'h10, 32'd1, 4'd4, cyc + 1);
        tick(); tick();

        // T3: same-cycle bypass of the broadcast into the new entry
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_val = 32'd9;
        dispatch(32'h40208233, 32'h108, 32'h0, 1'b0, 4'd0, 32'd3, 1'b1, 4'd6, 32'hBEEF, 4'd5, e0);
        cdb_valid = 1'b0;
        expect_issue(32'h40208233, 32'h108, 32'h0, 32'd3, 32'd9, 4'd5, e0 + 1);
        tick(); tick();

        // T4: fill DEPTH-1 blocked entries, then wake them all at once
        for (int k = 1; k <= 7; k++) begin
            dispatch(32'h1000 + 32'(k), 32'h200 + 32'(4 * k), 32'(k), 1'b1, 4'd1, 32'h0,
                     1'b0, 4'd0, 32'(k), 4'(7 + k), e0);
            chk("t4_rs_full", 32'(rs_full), (k >= 7) ? 32'd1 : 32'd0);
        end
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'hAB;
        tick();
        cdb_valid = 1'b0;
        w = cyc;
        chk("t4_full_at_wake", 32'(rs_full), 32'd1);
        for (int k = 1; k <= 7; k++)
            expect_issue(32'h1000 + 32'(k), 32'h200 + 32'(4 * k), 32'(k), 32'hAB, 32'(k),
                         4'(7 + k), w + k);
        tick();
        chk("t4_full_drop", 32'(rs_full), 32'd0);
        for (int k = 2; k <= 8; k++) tick();

        // T5: flush woken entries with a simultaneous dispatch
        for (int k = 1; k <= 4; k++)
            dispatch(32'h2000 + 32'(k), 32'h300, 32'h0, 1'b1, 4'd5, 32'h0,
                     1'b0, 4'd0, 32'(k), 4'(k), e0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 32'h55;
        tick();
        cdb_valid = 1'b0;
        clear = 1'b1;
        dispatch(32'h3000, 32'h400, 32'h0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd15, e0);
        clear = 1'b0;
        chk("t5_rs_full", 32'(rs_full), 32'd0);
        chk("t5_alu_valid", 32'(alu_valid), 32'd0);
        for (int k = 0; k < 4; k++) tick();
        dispatch(32'h3004, 32'h404, 32'h8, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h67, 4'd6, e0);
        expect_issue(32'h3004, 32'h404, 32'h8, 32'h66, 32'h67, 4'd6, e0 + 1);
        tick(); tick();

        // T6: freeze holds the pulse and ignores the broadcast; reset kills a pending issue
        dispatch(32'h5000, 32'h500, 32'h0, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'd4, 4'd2, e0);
        dispatch(32'h5004, 32'h504, 32'h0, 1'b0, 4'd0, 32'h91, 1'b0, 4'd0, 32'h92, 4'd9, e0);
        expect_issue(32'h5004, 32'h504, 32'h0, 32'h91, 32'h92, 4'd9, e0 + 1);
        tick();
        rdy_in = 1'b0; freeze = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'h77;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_hold_valid", 32'(alu_valid), 32'd1);
            chk("t6_hold_dest", 32'(alu_dest), 32'd9);
        end
        rdy_in = 1'b1; freeze = 1'b0; cdb_valid = 1'b0;
        tick(); tick(); tick();
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_val = 32'h21;
        tick();
        cdb_valid = 1'b0;
        rst_n_in = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(alu_valid), 32'd0);
        chk("t6_rst_dest", 32'(alu_dest), 32'd0);
        chk("t6_rst_v1", alu_v1, 32'd0);
        rst_n_in = 1'b1;
        tick(); tick(); tick();
        dispatch(32'h6000, 32'h600, 32'h4, 1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd12, 4'd13, e0);
        expect_issue(32'h6000, 32'h600, 32'h4, 32'd11, 32'd12, 4'd13, e0 + 1);
        tick(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
